// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//   Bundles the signals between the functional-unit result ports, the
//   common-data-bus arbiter and the CDB consumers (ROB / reservation stations).
//
//   req_valid  [NUM_REQ]            FU i has a result pending
//   req_rob    [NUM_REQ*ROB_IDX_W]  ROB index of FU i result (slice i)
//   req_data   [NUM_REQ*DATA_W]     result value of FU i (slice i)
//   req_ready  [NUM_REQ]            FU i result taken at this clock edge
//   CDBisCastN / CDBrobNumN / CDBdataN  broadcast channel N (N = 1, 2)
//
//   master : FU / consumer side (drives requests, observes the CDB)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 6,
  parameter int DATA_W    = 32
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]           req_ready;

  logic                         CDBisCast1;
  logic [ROB_IDX_W-1:0]         CDBrobNum1;
  logic [DATA_W-1:0]            CDBdata1;
  logic                         CDBisCast2;
  logic [ROB_IDX_W-1:0]         CDBrobNum2;
  logic [DATA_W-1:0]            CDBdata2;

  modport master (
    output req_valid, req_rob, req_data,
    input  req_ready,
    input  CDBisCast1, CDBrobNum1, CDBdata1,
    input  CDBisCast2, CDBrobNum2, CDBdata2
  );

  modport slave (
    input  req_valid, req_rob, req_data,
    output req_ready,
    output CDBisCast1, CDBrobNum1, CDBdata1,
    output CDBisCast2, CDBrobNum2, CDBdata2
  );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Shares the two common-data-bus broadcast channels between the functional
//   units completing into the ROB. Round-robin grants up to two completions
//   per cycle and drives registered one-cycle isCast pulses with robNum/data.
//   A cataclysm (branch mispredict flush) cancels grants for that cycle.
//
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   cataclysm  pipeline flush
//   bus        cdb_arbiter_if.slave: FU request/ready handshake + CDB1/CDB2
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 6,
  parameter int ROB_DEPTH = 16,
  parameter int DATA_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cataclysm,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ROB_IDX_W-1:0] INVALID_TAG = ROB_IDX_W'(ROB_DEPTH);

  // Round-robin pointer and registered broadcast channels
  logic [PTR_W-1:0]     rr_ptr;
  logic                 cast1_p1, cast2_p1;
  logic [ROB_IDX_W-1:0] rob1_p1, rob2_p1;
  logic [DATA_W-1:0]    data1_p1, data2_p1;

  // A channel that pulsed this cycle must idle next cycle so consumers see a
  // fresh rising edge; the cooldown is therefore exactly the pulse register.
  logic cool1, cool2;
  assign cool1 = cast1_p1;
  assign cool2 = cast2_p1;

  // Grant-stage signals
  logic [NUM_REQ-1:0]   ready_p0;
  logic                 hit1_p0, hit2_p0, any_p0;
  logic [PTR_W-1:0]     idx1_p0, idx2_p0, last_p0, next_ptr_p0;
  logic [ROB_IDX_W-1:0] rob1_p0, rob2_p0;
  logic [DATA_W-1:0]    data1_p0, data2_p0;
  logic                 cast1_p0, cast2_p0;

  // A tag at or beyond ROB_DEPTH marks a result nobody listens for.
  function automatic logic tag_ok(input logic [ROB_IDX_W-1:0] rob);
    return ({1'b0, rob} < (ROB_IDX_W + 1)'(ROB_DEPTH));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) >= NUM_REQ - 1)
      return '0;
    return p + 1'b1;
  endfunction

  // ---- stage p0: round-robin grant of free channels ----
  always_comb begin : grant_scan
    logic free1;
    logic free2;
    int   pos;
    ready_p0 = '0;
    hit1_p0  = 1'b0;
    hit2_p0  = 1'b0;
    idx1_p0  = '0;
    idx2_p0  = '0;
    last_p0  = rr_ptr;
    any_p0   = 1'b0;
    free1    = !cool1;
    free2    = !cool2;
    pos      = 0;
    if (rst_n && !cataclysm) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        pos = int'(rr_ptr) + k;
        if (pos >= NUM_REQ)
          pos = pos - NUM_REQ;
        if (bus.req_valid[pos]) begin
          // The first requester found takes the lowest-numbered free channel.
          if (free1) begin
            free1         = 1'b0;
            hit1_p0       = 1'b1;
            idx1_p0       = PTR_W'(pos);
            ready_p0[pos] = 1'b1;
            last_p0       = PTR_W'(pos);
            any_p0        = 1'b1;
          end else if (free2) begin
            free2         = 1'b0;
            hit2_p0       = 1'b1;
            idx2_p0       = PTR_W'(pos);
            ready_p0[pos] = 1'b1;
            last_p0       = PTR_W'(pos);
            any_p0        = 1'b1;
          end
        end
      end
    end
    rob1_p0     = bus.req_rob[int'(idx1_p0)*ROB_IDX_W +: ROB_IDX_W];
    rob2_p0     = bus.req_rob[int'(idx2_p0)*ROB_IDX_W +: ROB_IDX_W];
    data1_p0    = bus.req_data[int'(idx1_p0)*DATA_W +: DATA_W];
    data2_p0    = bus.req_data[int'(idx2_p0)*DATA_W +: DATA_W];
    // Invalid-tag grants consume the slot but raise no pulse and no cooldown.
    cast1_p0    = hit1_p0 && tag_ok(rob1_p0);
    cast2_p0    = hit2_p0 && tag_ok(rob2_p0);
    next_ptr_p0 = ptr_inc(last_p0);
  end

  assign bus.req_ready = ready_p0;

  // ---- stage p1: registered CDB broadcast ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      cast1_p1 <= 1'b0;
      cast2_p1 <= 1'b0;
      rob1_p1  <= INVALID_TAG;
      rob2_p1  <= INVALID_TAG;
      data1_p1 <= '0;
      data2_p1 <= '0;
    end else if (cataclysm) begin
      // Flush: drop pulses and cooldowns, keep fairness position and data.
      cast1_p1 <= 1'b0;
      cast2_p1 <= 1'b0;
      rob1_p1  <= INVALID_TAG;
      rob2_p1  <= INVALID_TAG;
    end else begin
      cast1_p1 <= cast1_p0;
      cast2_p1 <= cast2_p0;
      rob1_p1  <= cast1_p0 ? rob1_p0 : INVALID_TAG;
      rob2_p1  <= cast2_p0 ? rob2_p0 : INVALID_TAG;
      if (cast1_p0)
        data1_p1 <= data1_p0;
      if (cast2_p0)
        data2_p1 <= data2_p0;
      if (any_p0)
        rr_ptr <= next_ptr_p0;
    end
  end

  assign bus.CDBisCast1 = cast1_p1;
  assign bus.CDBrobNum1 = rob1_p1;
  assign bus.CDBdata1   = data1_p1;
  assign bus.CDBisCast2 = cast2_p1;
  assign bus.CDBrobNum2 = rob2_p1;
  assign bus.CDBdata2   = data2_p1;

endmodule
